// File: rtl/alu_mw_seq_pkg.sv
// ============================================================================
// Module  : alu_mw_seq_pkg
// Brief   : Shared types, widths and opcode helpers for the multi-word ALU sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_mw_seq_pkg;

  localparam int ALU_WORD     = 8;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] OP_SUM = 4'h1;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = 4'h2;
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND = 4'h3;
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes whose carry/borrow chains into the next word.
  function automatic logic is_arith(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == OP_SUM) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mw_seq.sv
// ============================================================================
// Module  : alu_mw_seq
// Brief   : Builds NWORDS*WIDTH add/sub/and/xor from successive single-word
//           ALU passes. Optional carry-in port: ALU_MW_SEQ_CARRY_IN_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mw_seq
  import alu_mw_seq_pkg::*;
#(
  parameter int WIDTH    = ALU_WORD,
  parameter int OP_WIDTH = ALU_OP_WIDTH,
  parameter int NWORDS   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [OP_WIDTH-1:0]        i_req_opcode,
  input  logic [NWORDS*WIDTH-1:0]    i_req_a,
  input  logic [NWORDS*WIDTH-1:0]    i_req_b,
`ifdef ALU_MW_SEQ_CARRY_IN_EN
  input  logic                       i_req_cin,
`endif
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [NWORDS*WIDTH-1:0]    o_rsp_result,
  output logic                       o_rsp_cf,
  output logic                       o_rsp_zero,
  output logic [WIDTH-1:0]           o_alu_a,
  output logic [WIDTH-1:0]           o_alu_b,
  output logic [OP_WIDTH-1:0]        o_alu_opcode,
  input  logic [WIDTH-1:0]           i_alu_result,
  input  logic                       i_alu_zero,
  input  logic                       i_alu_cf
);

  localparam int TOTAL = NWORDS * WIDTH;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OP_WIDTH-1:0]  r_op;
  logic [TOTAL-1:0]     r_a;
  logic [TOTAL-1:0]     r_b;
  logic [TOTAL-1:0]     r_acc;
  logic [TOTAL-1:0]     w_acc_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_carry;
  logic                 w_carry_nxt;
  logic [WIDTH-1:0]     r_tmp;
  logic                 r_cf1;
  logic                 w_advance;
  logic                 w_to_fix;
  logic                 w_carry_init;
  logic                 w_unused;

  // The ALU zero flag is redundant: the wide zero is taken from the full result.
  assign w_unused = i_alu_zero;

`ifdef ALU_MW_SEQ_CARRY_IN_EN
  assign w_carry_init = is_arith(i_req_opcode) & i_req_cin;
`else
  assign w_carry_init = 1'b0;
`endif

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_alu_a      = '0;
    o_alu_b      = '0;
    o_alu_opcode = '0;
    w_advance    = 1'b0;
    w_to_fix     = 1'b0;
    w_carry_nxt  = r_carry;
    case (r_state)
      ST_IDLE: if (i_req_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        o_alu_a      = r_a[int'(r_idx)*WIDTH +: WIDTH];
        o_alu_b      = r_b[int'(r_idx)*WIDTH +: WIDTH];
        o_alu_opcode = r_op;
        if (is_arith(r_op) && r_carry) begin
          w_to_fix    = 1'b1;
          w_state_nxt = ST_FIX;
        end else begin
          w_advance   = 1'b1;
          w_carry_nxt = is_arith(r_op) ? i_alu_cf : 1'b0;
        end
      end
      ST_FIX: begin
        // Second pass folds the carry/borrow-in; at most one of the two passes can carry.
        o_alu_a      = r_tmp;
        o_alu_b      = WIDTH'(1);
        o_alu_opcode = r_op;
        w_advance    = 1'b1;
        w_carry_nxt  = r_cf1 | i_alu_cf;
      end
      ST_DONE: if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_advance) w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_EXEC;
  end

  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[int'(r_idx)*WIDTH +: WIDTH] = i_alu_result;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_tmp        <= '0;
      r_cf1        <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_cf     <= 1'b0;
      o_rsp_zero   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_req_valid) begin
        r_op    <= i_req_opcode;
        r_a     <= i_req_a;
        r_b     <= i_req_b;
        r_idx   <= '0;
        r_carry <= w_carry_init;
      end
      if (w_to_fix) begin
        r_tmp <= i_alu_result;
        r_cf1 <= i_alu_cf;
      end
      if (w_advance) begin
        r_acc   <= w_acc_nxt;
        r_carry <= w_carry_nxt;
        if (r_idx == LAST_IDX) begin
          o_rsp_result <= w_acc_nxt;
          o_rsp_cf     <= w_carry_nxt;
          o_rsp_zero   <= (w_acc_nxt == '0);
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
